// File: rtl/bg_frame_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : bg_frame_loader_if
//  Description : Byte-stream input and BRAM write / status output bundle of
//                the background frame loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bg_frame_loader_if #(
    parameter int ADDR_W = 17
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_din;
    logic              busy;
    logic              loaded;
    logic              done;
    logic              err;

    // Loader side: consumes the UART byte stream, drives the BRAM port and status
    modport master (
        input  rx_data, rx_valid,
        output mem_we, mem_addr, mem_din, busy, loaded, done, err
    );

    // Environment side: byte source, BRAM and status consumer
    modport slave (
        output rx_data, rx_valid,
        input  mem_we, mem_addr, mem_din, busy, loaded, done, err
    );
endinterface
`default_nettype wire

// File: rtl/bg_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bg_frame_loader
//  Description : Receives a framed byte stream (A5 5A, pixel byte pairs, XOR
//                checksum), packs pairs into RGB444 pixels and writes them
//                sequentially into the background BRAM write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bg_frame_loader #(
    parameter int H_PIX   = 320,
    parameter int V_PIX   = 240,
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 2_500_000
) (
    input  wire                   clk,
    input  wire                   reset,
    bg_frame_loader_if.master     bus
);

    localparam int                c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] c_LAST_PIX = ADDR_W'(H_PIX * V_PIX - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]        c_SYNC0    = 8'hA5;
    localparam logic [7:0]        c_SYNC1    = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t              state_q,  state_d;
    logic [3:0]          nib_q,    nib_d;
    logic [7:0]          csum_q,   csum_d;
    logic [ADDR_W-1:0]   cnt_q,    cnt_d;
    logic [c_TMO_W-1:0]  tmo_q,    tmo_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [11:0]         din_q,    din_d;
    logic                loaded_q, loaded_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;

    // State and datapath registers; reset aborts any frame in progress at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            nib_q    <= '0;
            csum_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nib_q    <= nib_d;
            csum_q   <= csum_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Frame parser: next state, pixel packing, checksum, timeout and pulses
    always_comb begin
        state_d  = state_q;
        nib_d    = nib_q;
        csum_d   = csum_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // The write address advances after each write cycle and parks on the last pixel
        if (we_q && (addr_q != c_LAST_PIX)) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        // Inactivity watchdog: only runs inside a frame, restarts on every byte
        if (state_q == S_IDLE || bus.rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q == c_TMO_LAST) begin
            tmo_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            tmo_d = tmo_q + c_TMO_W'(1);
        end

        if (bus.rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_data == c_SYNC0) begin
                        state_d = S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (bus.rx_data == c_SYNC1) begin
                        state_d  = S_HI;
                        csum_d   = '0;
                        cnt_d    = '0;
                        addr_d   = '0;
                        loaded_d = 1'b0;
                    end else if (bus.rx_data != c_SYNC0) begin
                        // Broken preamble is silently dropped, not reported
                        state_d = S_IDLE;
                    end
                end
                S_HI: begin
                    nib_d   = bus.rx_data[3:0];
                    csum_d  = csum_q ^ bus.rx_data;
                    state_d = S_LO;
                end
                S_LO: begin
                    we_d   = 1'b1;
                    din_d  = {nib_q, bus.rx_data};
                    csum_d = csum_q ^ bus.rx_data;
                    if (cnt_q == c_LAST_PIX) begin
                        state_d = S_CHK;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = S_HI;
                    end
                end
                S_CHK: begin
                    if (bus.rx_data == csum_q) begin
                        done_d   = 1'b1;
                        loaded_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.loaded   = loaded_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bg_frame_loader
//  Description : Randomized self-checking bench for bg_frame_loader with a
//                byte-level reference model of the frame protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_frame_loader;

    localparam int H_PIX   = 4;
    localparam int V_PIX   = 2;
    localparam int ADDR_W  = 17;
    localparam int TIMEOUT = 50;
    localparam int NPIX    = H_PIX * V_PIX;

    logic clk;
    logic reset;

    bg_frame_loader_if #(.ADDR_W(ADDR_W)) bus();

    bg_frame_loader #(
        .H_PIX   (H_PIX),
        .V_PIX   (V_PIX),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int err_seen    = 0;
    int waddr_log[$];
    int wdin_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 waiting for A5, 1 waiting for 5A, 2 collecting payload, 3 waiting for checksum
    int         phase;
    int         idle;
    logic [7:0] payload[$];
    bit         m_we, m_loaded, m_done, m_err;
    int         m_addr;
    logic [11:0] m_din;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase = 0; idle = 0; payload.delete();
            m_we = 0; m_loaded = 0; m_done = 0; m_err = 0; m_addr = 0; m_din = '0;
        end else begin
            logic [7:0] x;
            m_we = 0; m_done = 0; m_err = 0;
            if (bus.rx_valid || phase == 0) begin
                idle = 0;
            end else begin
                idle++;
                if (idle >= TIMEOUT) begin
                    m_err = 1; phase = 0; idle = 0;
                end
            end
            if (bus.rx_valid) begin
                case (phase)
                    0: if (bus.rx_data == 8'hA5) phase = 1;
                    1: begin
                        if (bus.rx_data == 8'h5A) begin
                            phase = 2; payload.delete(); m_loaded = 0;
                        end else if (bus.rx_data != 8'hA5) begin
                            phase = 0;
                        end
                    end
                    2: begin
                        payload.push_back(bus.rx_data);
                        if (payload.size() % 2 == 0) begin
                            m_we   = 1;
                            m_addr = payload.size() / 2 - 1;
                            m_din  = {payload[payload.size() - 2][3:0], bus.rx_data};
                            if (payload.size() == 2 * NPIX) phase = 3;
                        end
                    end
                    default: begin
                        x = 8'h00;
                        foreach (payload[k]) x = x ^ payload[k];
                        if (x == bus.rx_data) begin
                            m_done = 1; m_loaded = 1;
                        end else begin
                            m_err = 1;
                        end
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            check("mem_we", 32'(bus.mem_we), 32'(m_we));
            check("busy",   32'(bus.busy),   32'(phase != 0));
            check("loaded", 32'(bus.loaded), 32'(m_loaded));
            check("done",   32'(bus.done),   32'(m_done));
            check("err",    32'(bus.err),    32'(m_err));
            if (m_we) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                check("mem_din",  32'(bus.mem_din),  32'(m_din));
            end
            if (bus.mem_we) begin
                waddr_log.push_back(int'(bus.mem_addr));
                wdin_log.push_back(int'(bus.mem_din));
            end
            if (bus.done) done_seen++;
            if (bus.err)  err_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // kind 0: pixel pairs (0x0i, 0x3C); kind 1: random bytes
    task automatic send_frame(input int kind, input bit good, input int maxgap);
        logic [7:0] d[2*NPIX];
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 2 * NPIX; i++) begin
            if (kind == 0) d[i] = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'h3C;
            else           d[i] = 8'($urandom);
            x = x ^ d[i];
        end
        send_byte(8'hA5, $urandom_range(0, maxgap));
        send_byte(8'h5A, $urandom_range(0, maxgap));
        for (int i = 0; i < 2 * NPIX; i++) send_byte(d[i], $urandom_range(0, maxgap));
        send_byte(good ? x : ~x, $urandom_range(0, maxgap));
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    int d0, e0;

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset        = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_we",   32'(bus.mem_we),   32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_din",  32'(bus.mem_din),  32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_loaded",   32'(bus.loaded),   32'd0);
        check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Reference frame with literal expectations
        waddr_log.delete(); wdin_log.delete(); d0 = done_seen; e0 = err_seen;
        send_frame(0, 1'b1, 2);
        settle();
        check("t1_nwrites", 32'(waddr_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < waddr_log.size(); k++) begin
            check("t1_addr", 32'(waddr_log[k]), 32'(k));
            check("t1_din",  32'(wdin_log[k]),  32'h13C + 32'(k) * 32'h100);
        end
        check("t1_done", 32'(done_seen - d0), 32'd1);
        check("t1_loaded", 32'(bus.loaded), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd0);

        // Bad checksum
        waddr_log.delete(); d0 = done_seen; e0 = err_seen;
        send_frame(0, 1'b0, 1);
        settle();
        check("t2_nwrites", 32'(waddr_log.size()), 32'd8);
        check("t2_err", 32'(err_seen - e0), 32'd1);
        check("t2_done", 32'(done_seen - d0), 32'd0);
        check("t2_loaded", 32'(bus.loaded), 32'd0);

        // Tolerated double A5 after junk
        d0 = done_seen;
        send_byte(8'h00, 0);
        send_byte(8'hA5, 1);
        send_frame(0, 1'b1, 1);
        settle();
        check("t3_done", 32'(done_seen - d0), 32'd1);

        // Broken preamble
        waddr_log.delete(); e0 = err_seen;
        send_byte(8'hA5, 0); send_byte(8'h11, 0); send_byte(8'h5A, 0);
        settle();
        check("t4_nwrites", 32'(waddr_log.size()), 32'd0);
        check("t4_err", 32'(err_seen - e0), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd0);

        // Timeout after 3 pairs
        e0 = err_seen;
        send_byte(8'hA5, 0); send_byte(8'h5A, 0);
        for (int i = 0; i < 6; i++) send_byte(8'h21, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        #1;
        check("t5_err_early", 32'(err_seen - e0), 32'd0);
        @(negedge clk);
        #1;
        check("t5_err", 32'(err_seen - e0), 32'd1);
        check("t5_busy", 32'(bus.busy), 32'd0);
        waddr_log.delete();
        send_frame(0, 1'b1, 0);
        settle();
        check("t5_restart_addr", (waddr_log.size() > 0) ? 32'(waddr_log[0]) : 32'hFFFF, 32'd0);
        check("t5_loaded", 32'(bus.loaded), 32'd1);

        // Back-to-back bytes, randomized payloads and random junk
        for (int f = 0; f < 6; f++) send_frame(1, ($urandom_range(0, 3) != 0), (f < 2) ? 0 : 3);
        for (int j = 0; j < 40; j++) send_byte((j % 5 == 0) ? 8'hA5 : 8'($urandom), $urandom_range(0, 2));
        repeat (TIMEOUT + 5) @(negedge clk);

        // Asynchronous reset during pair 5 while a write is active
        send_byte(8'hA5, 0); send_byte(8'h5A, 0);
        for (int i = 0; i < 8; i++) send_byte(8'h44, 0);
        bus.rx_data  = 8'h05;
        bus.rx_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("t6_mem_we", 32'(bus.mem_we), 32'd0);
        check("t6_busy",   32'(bus.busy),   32'd0);
        check("t6_loaded", 32'(bus.loaded), 32'd0);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        waddr_log.delete();
        for (int i = 0; i < 6; i++) send_byte(8'h3C, 0);
        settle();
        check("t6_nowrites", 32'(waddr_log.size()), 32'd0);
        send_frame(1, 1'b1, 1);
        settle();
        check("t6_loaded_after", 32'(bus.loaded), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
